// File: rtl/sparse_vector_compressor.sv
// Sparse vector compressor: takes one dense vector of signed lanes and packs
// the lanes whose magnitude is above a programmable threshold into the low
// output slots, in lane order. It also emits an occupancy bitmap and a count.
// A bypass mode passes the whole vector through unchanged.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The sender holds its payload stable while valid && !ready. The block
// accepts a new vector only in IDLE, so at most one vector is in flight.
module sparse_vector_compressor #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 16,
  parameter int CNT_W      = $clog2(NUM_LANES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           cfg_threshold,
  input  logic                            cfg_bypass,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  input  logic                            valid_in,
  output logic                            ready_in,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
  output logic [NUM_LANES-1:0]            index_out,
  output logic [CNT_W-1:0]                nnz_out,
  output logic                            valid_out,
  input  logic                            ready_out,
  output logic                            busy,
  output logic [1:0]                      state_dbg
);

  localparam int VEC_W  = NUM_LANES * DATA_WIDTH;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [VEC_W-1:0]      cap_data_q, cap_data_d;
  logic [DATA_WIDTH-1:0] thr_q, thr_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  // The kept-element count doubles as the write pointer into data_out.
  logic [CNT_W-1:0]      nnz_q, nnz_d;
  logic [VEC_W-1:0]      data_out_q, data_out_d;
  logic [NUM_LANES-1:0]  index_q, index_d;
  logic                  valid_out_q, valid_out_d;
  logic                  ready_in_q, ready_in_d;

  logic [DATA_WIDTH-1:0] cur_lane;
  logic [DATA_WIDTH:0]   cur_ext;
  logic [DATA_WIDTH:0]   cur_mag;
  logic                  keep;

  // Magnitude of the lane under scan, one bit wider so the most-negative
  // value maps to 2^(DATA_WIDTH-1) without saturating.
  always_comb begin
    cur_lane = cap_data_q[lane_q*DATA_WIDTH +: DATA_WIDTH];
    cur_ext  = {cur_lane[DATA_WIDTH-1], cur_lane};
    cur_mag  = cur_lane[DATA_WIDTH-1] ? (~cur_ext + 1'b1) : cur_ext;
    keep     = (cur_mag > {1'b0, thr_q});
  end

  // Next-state and datapath updates for the IDLE/SCAN/OUTPUT controller.
  always_comb begin
    state_d    = state_q;
    cap_data_d = cap_data_q;
    thr_d      = thr_q;
    lane_d     = lane_q;
    nnz_d      = nnz_q;
    data_out_d = data_out_q;
    index_d    = index_q;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_in_q) begin
          cap_data_d = data_in;
          thr_d      = cfg_threshold;
          lane_d     = '0;
          if (cfg_bypass) begin
            data_out_d = data_in;
            index_d    = '1;
            nnz_d      = CNT_W'(NUM_LANES);
            state_d    = OUTPUT;
          end else begin
            data_out_d = '0;
            index_d    = '0;
            nnz_d      = '0;
            state_d    = SCAN;
          end
        end
      end
      SCAN: begin
        if (keep) begin
          data_out_d[nnz_q*DATA_WIDTH +: DATA_WIDTH] = cur_lane;
          index_d[lane_q] = 1'b1;
          nnz_d           = nnz_q + CNT_W'(1);
        end
        if (lane_q == LAST_LANE) begin
          state_d = OUTPUT;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      OUTPUT: begin
        if (valid_out_q && ready_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // valid_out trails entry into OUTPUT by one edge and drops on handshake.
    valid_out_d = (state_q == OUTPUT) && !(valid_out_q && ready_out);
    ready_in_d  = (state_d == IDLE);
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_data_q  <= '0;
      thr_q       <= '0;
      lane_q      <= '0;
      nnz_q       <= '0;
      data_out_q  <= '0;
      index_q     <= '0;
      valid_out_q <= 1'b0;
      ready_in_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_data_q  <= cap_data_d;
      thr_q       <= thr_d;
      lane_q      <= lane_d;
      nnz_q       <= nnz_d;
      data_out_q  <= data_out_d;
      index_q     <= index_d;
      valid_out_q <= valid_out_d;
      ready_in_q  <= ready_in_d;
    end
  end

  assign ready_in  = ready_in_q;
  assign data_out  = data_out_q;
  assign index_out = index_q;
  assign nnz_out   = nnz_q;
  assign valid_out = valid_out_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
